// File: rtl/virtual_ds2431_io.sv
// virtual_ds2431_io: 1-Wire slave bit layer (reset/presence, byte shift in/out) for a DS2431 emulator
module virtual_ds2431_io #(
    parameter int CLK_MHZ = 50
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       IO_i,
    output logic       IO_o,
    output logic       nBusRst,
    output logic       nODBusRst,
    input  logic       odMode,
    input  logic       nRxTx,
    input  logic       trig,
    input  logic [7:0] sentDat,
    output logic [7:0] receiveDat,
    output logic       done
);
    localparam logic [15:0] STD_RST  = 16'(400 * CLK_MHZ);
    localparam logic [15:0] OD_RST   = 16'(45 * CLK_MHZ);
    localparam logic [15:0] STD_SLOT = 16'(30 * CLK_MHZ);
    localparam logic [15:0] OD_SLOT  = 16'(3 * CLK_MHZ);
    localparam logic [15:0] STD_PW   = 16'(15 * CLK_MHZ);
    localparam logic [15:0] OD_PW    = 16'(2 * CLK_MHZ);
    localparam logic [15:0] STD_PD   = 16'(120 * CLK_MHZ);
    localparam logic [15:0] OD_PD    = 16'(10 * CLK_MHZ);

    typedef enum logic [2:0] {IDLE, LOW, WAIT_HIGH, PRES_WAIT, PRES_DRIVE} stateT;

    stateT       state, nextState;
    logic        ioMeta, ioSync, ioPrev, timing, armed, slotOd, slotTx, presOd;
    logic [15:0] lowTimer, cnt, slotT, presWaitT, presDrvT;
    logic [2:0]  bitCnt;
    logic [7:0]  shReg;
    logic        fall, rise, masterFall, stdRst, odRst, busRst, bitDone;

    // Pad drive, master-edge qualification, reset classification at bus rise, next state
    always_comb begin
        IO_o       = !(state == PRES_DRIVE || (state == LOW && slotTx && !shReg[0]));
        fall       = ioPrev & ~ioSync;
        rise       = ~ioPrev & ioSync;
        masterFall = fall && IO_o && state != PRES_WAIT && state != PRES_DRIVE;
        stdRst     = rise && timing && lowTimer >= STD_RST;
        odRst      = rise && timing && !stdRst && odMode && lowTimer >= OD_RST;
        busRst     = stdRst || odRst;
        slotT      = slotOd ? OD_SLOT : STD_SLOT;
        presWaitT  = presOd ? OD_PW : STD_PW;
        presDrvT   = presOd ? OD_PD : STD_PD;
        bitDone    = state == LOW && cnt == slotT - 16'd1;
        nextState  = state;
        if (busRst)
            nextState = PRES_WAIT;
        else
            case (state)
                IDLE:       nextState = (masterFall && armed && !done) ? LOW : IDLE;
                LOW:        nextState = !trig ? IDLE : bitDone ? WAIT_HIGH : LOW;
                WAIT_HIGH:  nextState = (!trig || ioSync) ? IDLE : WAIT_HIGH;
                PRES_WAIT:  nextState = (cnt == presWaitT - 16'd1) ? PRES_DRIVE : PRES_WAIT;
                PRES_DRIVE: nextState = (cnt == presDrvT - 16'd1) ? IDLE : PRES_DRIVE;
                default:    nextState = IDLE;
            endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (nRst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Bus synchronizer, low/slot timers, reset pulses and byte shift register
    always_ff @(posedge clk) begin
        if (nRst) begin
            ioMeta     <= 1'b1;
            ioSync     <= 1'b1;
            ioPrev     <= 1'b1;
            cnt        <= '0;
            timing     <= 1'b0;
            lowTimer   <= '0;
            nBusRst    <= 1'b1;
            nODBusRst  <= 1'b1;
            presOd     <= 1'b0;
            slotOd     <= 1'b0;
            slotTx     <= 1'b0;
            armed      <= 1'b0;
            bitCnt     <= '0;
            shReg      <= '0;
            receiveDat <= '0;
            done       <= 1'b0;
        end else begin
            ioMeta    <= IO_i;
            ioSync    <= ioMeta;
            ioPrev    <= ioSync;
            cnt       <= (nextState != state) ? '0 : (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
            timing    <= masterFall ? 1'b1 : rise ? 1'b0 : timing;
            lowTimer  <= masterFall ? 16'd1 :
                         (timing && !ioSync && lowTimer != 16'hFFFF) ? lowTimer + 16'd1 : lowTimer;
            nBusRst   <= !stdRst;
            nODBusRst <= !odRst;
            if (busRst) begin
                presOd <= odRst;
                bitCnt <= '0;
                done   <= 1'b0;
                armed  <= 1'b0;
            end else if (!trig) begin
                done  <= 1'b0;
                armed <= 1'b0;
            end else if (state == IDLE && !done && !armed) begin
                armed  <= 1'b1;
                shReg  <= sentDat;
                bitCnt <= '0;
            end else if (state == IDLE && nextState == LOW) begin
                slotOd <= odMode;
                slotTx <= nRxTx;
            end else if (bitDone) begin
                shReg  <= {ioSync, shReg[7:1]};
                bitCnt <= bitCnt + 3'd1;
                if (bitCnt == 3'd7) begin
                    done  <= 1'b1;
                    armed <= 1'b0;
                    if (!slotTx)
                        receiveDat <= {ioSync, shReg[7:1]};
                end
            end
        end
    end
endmodule

// File: tb/tb_virtual_ds2431_io.sv
// tb_virtual_ds2431_io: randomized directed bench with a 1-Wire master and spec-level reference model
`timescale 1ns/1ps
module tb_virtual_ds2431_io;
    localparam int  MHZ  = 5;
    localparam time CLKP = 1000 / MHZ;

    logic       clk = 1'b0, nRst = 1'b1, masterDrv = 1'b1;
    logic       odMode = 1'b0, nRxTx = 1'b0, trig = 1'b0;
    logic [7:0] sentDat = 8'h00;
    logic       IO_o, nBusRst, nODBusRst, done, bus;
    logic [7:0] receiveDat;

    int  checks = 0, errors = 0;
    int  busRstCnt = 0, odRstCnt = 0, ioFalls = 0;
    time ioFallT = 0, ioRiseT = 0;

    assign bus = masterDrv & IO_o;
    always #(CLKP / 2) clk = ~clk;

    virtual_ds2431_io #(.CLK_MHZ(MHZ)) dut (
        .clk(clk), .nRst(nRst), .IO_i(bus), .IO_o(IO_o), .nBusRst(nBusRst),
        .nODBusRst(nODBusRst), .odMode(odMode), .nRxTx(nRxTx), .trig(trig),
        .sentDat(sentDat), .receiveDat(receiveDat), .done(done)
    );

    always @(posedge clk) begin
        if (nBusRst === 1'b0) busRstCnt <= busRstCnt + 1;
        if (nODBusRst === 1'b0) odRstCnt <= odRstCnt + 1;
    end
    always @(negedge IO_o) begin
        ioFalls <= ioFalls + 1;
        ioFallT <= $time;
    end
    always @(posedge IO_o) ioRiseT <= $time;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkRange(input string tag, input time obs, input time lo, input time hi);
        checks++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d required=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Spec rules for a master low pulse of lowNs: which reset fires and the presence that follows
    task automatic refReset(input time lowNs, input logic od, output int eStd, output int eOd,
                            output time pWait, output time pLen);
        eStd  = (lowNs >= 400000) ? 1 : 0;
        eOd   = (eStd == 0 && od && lowNs >= 45000) ? 1 : 0;
        pWait = eStd ? 15000 : 2000;
        pLen  = eStd ? 120000 : eOd ? 10000 : 0;
    endtask

    task automatic slot(input time lowNs, input time periodNs, input time sampleNs, output logic sampled);
        @(negedge clk);
        masterDrv = 1'b0;
        #(lowNs) masterDrv = 1'b1;
        #(sampleNs - lowNs) sampled = bus;
        #(periodNs - sampleNs);
    endtask

    task automatic busReset(input time lowNs, input logic od);
        int  b0, o0, f0, eStd, eOd;
        time tRel, pWait, pLen;
        refReset(lowNs, od, eStd, eOd, pWait, pLen);
        odMode = od;
        b0 = busRstCnt;
        o0 = odRstCnt;
        @(negedge clk);
        masterDrv = 1'b0;
        #(lowNs) masterDrv = 1'b1;
        tRel = $time;
        f0 = ioFalls;
        #(200000);
        check("nBusRst", busRstCnt - b0, eStd);
        check("nODBusRst", odRstCnt - o0, eOd);
        check("presCount", ioFalls - f0, (pLen != 0) ? 1 : 0);
        if (pLen != 0) begin
            checkRange("presStart", ioFallT - tRel, pWait, pWait + 1200);
            checkRange("presLen", ioRiseT - ioFallT, pLen - CLKP, pLen + CLKP);
        end
    endtask

    task automatic txByte(input logic [7:0] b, input logic od, input int n, input logic arm);
        logic s, expBit;
        int   f0;
        time  drv;
        drv    = od ? 3000 : 30000;
        odMode = od;
        nRxTx  = 1'b1;
        if (arm) begin
            sentDat = b;
            trig    = 1'b1;
            repeat (4) @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            f0 = ioFalls;
            slot(od ? 1000 : 6250, od ? 9000 : 57000, od ? 2000 : 15000, s);
            expBit = (i < 8) ? b[i] : 1'b1;
            check("txBit", s, expBit);
            check("txDrive", ioFalls - f0, expBit ? 0 : 1);
            if (!expBit) checkRange("txDriveLen", ioRiseT - ioFallT, drv - CLKP, drv + CLKP);
            check("txDone", done, (i >= 7) ? 1 : 0);
        end
    endtask

    task automatic rxByte(input logic [7:0] b, input logic od, input int n, input logic arm);
        logic s;
        time  lowNs;
        odMode = od;
        nRxTx  = 1'b0;
        if (arm) begin
            trig = 1'b1;
            repeat (4) @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            lowNs = b[i] ? (od ? 1200 : 2200) : (od ? 7400 : 57000);
            slot(lowNs, od ? 10000 : 70000, lowNs, s);
        end
        if (n == 8) begin
            check("rxDat", receiveDat, b);
            check("rxDone", done, 1);
        end else
            check("rxDonePart", done, 0);
    endtask

    task automatic endXfer();
        trig = 1'b0;
        repeat (3) @(negedge clk);
        check("doneClr", done, 0);
        check("ioIdle", IO_o, 1);
    endtask

    initial begin
        logic [7:0] b, c;
        repeat (5) @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        check("rstIO", IO_o, 1);
        check("rstBus", nBusRst, 1);
        check("rstOD", nODBusRst, 1);
        check("rstRx", receiveDat, 0);
        check("rstDone", done, 0);

        busReset(time'($urandom_range(410, 600)) * 1000, 1'b0);
        busReset(480000, 1'b1);
        busReset(48200, 1'b1);
        busReset(48200, 1'b0);
        busReset(time'($urandom_range(46, 380)) * 1000, 1'b1);
        busReset(time'($urandom_range(46, 380)) * 1000, 1'b0);

        txByte(8'hA5, 1'b0, 9, 1'b1); endXfer();
        txByte(8'hA5, 1'b1, 9, 1'b1); endXfer();
        txByte(8'($urandom), 1'b0, 9, 1'b1); endXfer();
        txByte(8'($urandom), 1'b1, 9, 1'b1); endXfer();

        rxByte(8'h33, 1'b0, 8, 1'b1); endXfer();
        rxByte(8'hCC, 1'b1, 8, 1'b1); endXfer();
        rxByte(8'($urandom), 1'b0, 8, 1'b1); endXfer();
        rxByte(8'($urandom), 1'b1, 8, 1'b1); endXfer();

        b = 8'($urandom);
        c = 8'($urandom);
        rxByte(b, 1'b1, 3, 1'b1);
        busReset(48200, 1'b1);
        check("abortOdDone", done, 0);
        rxByte(c, 1'b1, 8, 1'b0);
        endXfer();

        b = 8'($urandom);
        txByte(b, 1'b0, 3, 1'b1);
        busReset(480000, 1'b0);
        check("abortStdDone", done, 0);
        txByte(b, 1'b0, 8, 1'b0);
        endXfer();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
